adc_query: RTL and testbench
============================

# adc_query

Request/response engine for one ADC conversion over the board UART link. On a `start` pulse it sends the channel's command byte (0xA1..0xA4) into the UART TX stream, collects the two-byte reply from the UART RX stream (low byte first), and presents one 16-bit sample with its channel tag on a valid/ready output. It sits between a channel scheduler or host logic and the `uart` core, replacing ad-hoc polling FSMs in top-level designs. Missing replies are caught by a timeout.

## Interface
- `CMD_BASE`, 8'hA1: command byte for channel 0; channel n sends `CMD_BASE + n`.
- `TIMEOUT_CYCLES`, 12000: clk cycles without an RX byte, while waiting, before the query is aborted (1 ms at 12 MHz).

- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: query request; sampled only in IDLE.
- `ch`  in  2: channel for `start`; captured with it.
- `cmd_tdata`  out  8: command byte to UART `s_axis_tdata`.
- `cmd_tvalid`  out  1: command valid.
- `cmd_tready`  in  1: UART TX ready.
- `rsp_tdata`  in  8: reply byte from UART `m_axis_tdata`.
- `rsp_tvalid`  in  1: reply byte valid.
- `rsp_tready`  out  1: always 1 when not in reset; bytes are never back-pressured.
- `sample_data`  out  16: `{hi, lo}` reply.
- `sample_ch`  out  2: channel of `sample_data`.
- `sample_valid`  out  1: sample available.
- `sample_ready`  in  1: consumer accepts the sample.
- `sample_clip`  out  1: the sample was saturated (see Configuration).
- `busy`  out  1: state is not IDLE.
- `timeout_pulse`  out  1: one-cycle pulse when a query is aborted.
- `timeout_count`  out  8: number of aborted queries; saturates at 255.

## Operation
- States: IDLE, SEND, WAIT_LO, WAIT_HI, OUT.
- **IDLE:** `start`=1 latches `ch`, loads `cmd_tdata`=`CMD_BASE`+`ch` (8-bit wrap) and sets `cmd_tvalid`. Next state is SEND.
- **SEND:** hold `cmd_tvalid`/`cmd_tdata` until `cmd_tvalid & cmd_tready`. On that handshake, drop `cmd_tvalid`, clear the timeout counter and go to WAIT_LO.
- **WAIT_LO:** an RX byte is stored as `lo`; clear the timeout counter and go to WAIT_HI.
- **WAIT_HI:** an RX byte is stored as `hi`. Update `sample_data`/`sample_ch`/`sample_clip`, set `sample_valid` and go to OUT.
- **OUT:** hold the sample until `sample_valid & sample_ready`, then clear `sample_valid` and go to IDLE.
- **Timeout:** in WAIT_LO or WAIT_HI the counter increments each cycle with no RX byte. When it reaches `TIMEOUT_CYCLES`-1:
  - pulse `timeout_pulse`;
  - increment `timeout_count` (saturating);
  - discard any partial byte;
  - go to IDLE. No sample is produced.
- **Stray bytes:** RX bytes in IDLE, SEND or OUT are accepted and dropped.
- **Ignored starts:** `start` outside IDLE is ignored, not queued.

## Timing
- **Reset values:** while `rst` is high, all of the following are 0: `cmd_tdata`, `cmd_tvalid`, `rsp_tready`, `sample_data`, `sample_ch`, `sample_valid`, `sample_clip`, `busy`, `timeout_pulse`, `timeout_count`. State is IDLE and the timeout counter is 0.
- **Reset mid-query:** asserting `rst` abandons the query immediately. After release the block is in IDLE and ignores late reply bytes.
- **Command latency:** `start` at cycle N gives `cmd_tvalid`=1 at N+1. `busy`=1 from N+1 until the cycle after the sample handshake or the timeout.
- **Sample latency:** the hi byte accepted at cycle M gives `sample_valid`=1 at M+1.
- **Back-to-back queries:** a `start` in the first IDLE cycle after a sample handshake is accepted.
- **Byte vs. timeout:** if an RX byte arrives in the same cycle the counter hits its limit, the byte wins and no timeout occurs.
- **Exact timeout point:** entering WAIT_LO at cycle K with no RX traffic gives `timeout_pulse` at K+`TIMEOUT_CYCLES`, and IDLE on the same edge.

## Configuration
- **`ADC_CLIP_10BIT_EN` defined:** if `hi[7:2]` is nonzero, `sample_data` is forced to 16'h03FF and `sample_clip`=1 for that sample; otherwise `sample_clip`=0.
- **`ADC_CLIP_10BIT_EN` undefined:** `sample_data` is the raw `{hi, lo}` and `sample_clip` is tied to 0.

## Test plan
- **Basic query:** `start` with `ch`=2, `cmd_tready`=1, reply bytes 0x34 then 0x01 -> `cmd_tdata`=0xA3 for one handshake; `sample_data`=0x0134, `sample_ch`=2, `sample_valid` held until `sample_ready`.
- **TX back-pressure:** `cmd_tready`=0 for 10 cycles after `start` with `ch`=0 -> `cmd_tvalid`=1 and `cmd_tdata`=0xA1 stable throughout; exactly one handshake.
- **Timeout:** `TIMEOUT_CYCLES`=16, one reply byte 0x55 then silence -> `timeout_pulse` 16 cycles after that byte; `timeout_count`=1; no `sample_valid`; next query with reply 0x10,0x00 -> `sample_data`=0x0010.
- **Stray bytes and ignored starts:** RX byte 0xFF in IDLE, plus `start` in WAIT_HI -> byte dropped, second `start` ignored, sample uses only the in-query bytes.
- **Clip (with `ADC_CLIP_10BIT_EN`):** reply 0x00,0x04 -> `sample_data`=0x03FF, `sample_clip`=1. Without the macro -> 0x0400, `sample_clip`=0.
- **Reset mid-query:** `rst` pulse during WAIT_HI -> all outputs 0 at once; following RX bytes dropped; `busy`=0.

Source files
------------

// File: rtl/adc_query_if.sv
// Handshake bundle between adc_query and its environment: scheduler request,
// UART TX command stream, UART RX reply stream and the sample output.
interface adc_query_if;
   logic        start;
   logic [1:0]  ch;
   logic [7:0]  cmd_tdata;
   logic        cmd_tvalid;
   logic        cmd_tready;
   logic [7:0]  rsp_tdata;
   logic        rsp_tvalid;
   logic        rsp_tready;
   logic [15:0] sample_data;
   logic [1:0]  sample_ch;
   logic        sample_valid;
   logic        sample_ready;
   logic        sample_clip;
   logic        busy;
   logic        timeout_pulse;
   logic [7:0]  timeout_count;

   modport master (
      input  start, ch, cmd_tready, rsp_tdata, rsp_tvalid, sample_ready,
      output cmd_tdata, cmd_tvalid, rsp_tready, sample_data, sample_ch,
             sample_valid, sample_clip, busy, timeout_pulse, timeout_count
   );

   modport slave (
      output start, ch, cmd_tready, rsp_tdata, rsp_tvalid, sample_ready,
      input  cmd_tdata, cmd_tvalid, rsp_tready, sample_data, sample_ch,
             sample_valid, sample_clip, busy, timeout_pulse, timeout_count
   );
endinterface

// File: rtl/adc_query.sv
// One ADC conversion over the UART link: send command byte, collect lo/hi reply,
// present a 16-bit sample. Optional 10-bit clipping via ADC_CLIP_10BIT_EN.
//
// state   | meaning
// IDLE    | waiting for start; stray RX bytes dropped
// SEND    | command byte offered to UART TX
// WAIT_LO | waiting for low reply byte, timeout armed
// WAIT_HI | waiting for high reply byte, timeout armed
// OUT     | sample held until consumer accepts it
module adc_query #(
   parameter logic [7:0] CMD_BASE       = 8'hA1,
   parameter int         TIMEOUT_CYCLES = 12000
) (
   input  logic         clk,
   input  logic         rst,
   adc_query_if.master  io
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, SEND, WAIT_LO, WAIT_HI, OUT} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [7:0]      lo;
   logic [1:0]      ch_q;
   logic            tmo;

   // A byte arriving on the terminal cycle wins over the timeout.
   assign tmo     = (cnt == CW'(TIMEOUT_CYCLES - 1)) && !io.rsp_tvalid;
   assign io.busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (io.start) state_nxt = SEND;
         SEND:    if (io.cmd_tready) state_nxt = WAIT_LO;
         WAIT_LO: begin
            if (io.rsp_tvalid) state_nxt = WAIT_HI;
            else if (tmo)      state_nxt = IDLE;
         end
         WAIT_HI: begin
            if (io.rsp_tvalid) state_nxt = OUT;
            else if (tmo)      state_nxt = IDLE;
         end
         OUT:     if (io.sample_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io.cmd_tdata     <= 8'h00;
         io.cmd_tvalid    <= 1'b0;
         io.rsp_tready    <= 1'b0;
         io.sample_data   <= 16'h0000;
         io.sample_ch     <= 2'd0;
         io.sample_valid  <= 1'b0;
         io.sample_clip   <= 1'b0;
         io.timeout_pulse <= 1'b0;
         io.timeout_count <= 8'h00;
         cnt              <= '0;
         lo               <= 8'h00;
         ch_q             <= 2'd0;
      end else begin
         io.rsp_tready    <= 1'b1;
         io.timeout_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (io.start) begin
                  ch_q          <= io.ch;
                  io.cmd_tdata  <= CMD_BASE + {6'd0, io.ch};
                  io.cmd_tvalid <= 1'b1;
               end
            end
            SEND: begin
               if (io.cmd_tready) begin
                  io.cmd_tvalid <= 1'b0;
                  cnt           <= '0;
               end
            end
            WAIT_LO, WAIT_HI: begin
               if (io.rsp_tvalid) begin
                  cnt <= '0;
                  if (state == WAIT_LO) begin
                     lo <= io.rsp_tdata;
                  end else begin
                     io.sample_ch    <= ch_q;
                     io.sample_valid <= 1'b1;
`ifdef ADC_CLIP_10BIT_EN
                     if (|io.rsp_tdata[7:2]) begin
                        io.sample_data <= 16'h03FF;
                        io.sample_clip <= 1'b1;
                     end else begin
                        io.sample_data <= {io.rsp_tdata, lo};
                        io.sample_clip <= 1'b0;
                     end
`else
                     io.sample_data <= {io.rsp_tdata, lo};
                     io.sample_clip <= 1'b0;
`endif
                  end
               end else if (tmo) begin
                  io.timeout_pulse <= 1'b1;
                  if (io.timeout_count != 8'hFF)
                     io.timeout_count <= io.timeout_count + 8'd1;
                  lo  <= 8'h00;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            OUT: begin
               if (io.sample_ready) io.sample_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_query.sv
// Directed bench for adc_query with a sample scoreboard; short timeout (16 cycles).
module tb_adc_query;

   localparam int         TO = 16;
   localparam logic [7:0] CB = 8'hA1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   adc_query_if bus();

   adc_query #(.CMD_BASE(CB), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   typedef struct packed {
      logic [1:0]  ch;
      logic [15:0] data;
      logic        clip;
   } samp_t;

   samp_t sb[$];
   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int hs_count = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.cmd_tvalid && bus.cmd_tready) hs_count <= hs_count + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic samp_t model(input logic [1:0] c, input logic [7:0] lo, input logic [7:0] hi);
      samp_t s;
      s.ch = c;
`ifdef ADC_CLIP_10BIT_EN
      if (hi[7:2] != 6'd0) begin
         s.data = 16'h03FF;
         s.clip = 1'b1;
      end else begin
         s.data = {hi, lo};
         s.clip = 1'b0;
      end
`else
      s.data = {hi, lo};
      s.clip = 1'b0;
`endif
      return s;
   endfunction

   task automatic check_out(input string tag);
      samp_t e;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL %s: observed a sample, expected none queued", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_data"}, 32'(bus.sample_data), 32'(e.data));
         chk({tag, "_ch"},   32'(bus.sample_ch),   32'(e.ch));
         chk({tag, "_clip"}, 32'(bus.sample_clip), 32'(e.clip));
      end
   endtask

   // start -> optional TX stall -> handshake -> lo, hi -> held sample -> accept
   task automatic run_query(input logic [1:0] c, input logic [7:0] lo, input logic [7:0] hi,
                            input int bp, input bit poke);
      int hs0;
      hs0 = hs_count;
      bus.cmd_tready = 1'b0;
      bus.start = 1'b1;
      bus.ch = c;
      tick;
      bus.start = 1'b0;
      bus.ch = 2'd0;
      chk("cmd_tvalid", 32'(bus.cmd_tvalid), 1);
      chk("cmd_tdata", 32'(bus.cmd_tdata), 32'(8'(CB + 8'(c))));
      chk("busy_start", 32'(bus.busy), 1);
      for (int i = 0; i < bp; i++) begin
         tick;
         chk("cmd_hold_valid", 32'(bus.cmd_tvalid), 1);
         chk("cmd_hold_data", 32'(bus.cmd_tdata), 32'(8'(CB + 8'(c))));
      end
      bus.cmd_tready = 1'b1;
      tick;
      bus.cmd_tready = 1'b0;
      chk("cmd_drop", 32'(bus.cmd_tvalid), 0);
      chk("cmd_handshakes", 32'(hs_count - hs0), 1);
      bus.rsp_tvalid = 1'b1;
      bus.rsp_tdata = lo;
      tick;
      bus.rsp_tdata = hi;
      if (poke) begin
         bus.start = 1'b1;
         bus.ch = ~c;
      end
      sb.push_back(model(c, lo, hi));
      tick;
      bus.rsp_tvalid = 1'b0;
      bus.start = 1'b0;
      chk("sample_valid", 32'(bus.sample_valid), 1);
      bus.sample_ready = 1'b0;
      tick;
      tick;
      chk("sample_hold", 32'(bus.sample_valid), 1);
      if (poke) chk("ignored_start", 32'(bus.cmd_tvalid), 0);
      check_out("sample");
      bus.sample_ready = 1'b1;
      tick;
      bus.sample_ready = 1'b0;
      chk("sample_release", 32'(bus.sample_valid), 0);
      chk("busy_after", 32'(bus.busy), 0);
   endtask

   task automatic begin_query(input logic [1:0] c);
      bus.start = 1'b1;
      bus.ch = c;
      bus.cmd_tready = 1'b1;
      tick;
      bus.start = 1'b0;
      tick;
      bus.cmd_tready = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_cmd_tdata"},     32'(bus.cmd_tdata), 0);
      chk({tag, "_cmd_tvalid"},    32'(bus.cmd_tvalid), 0);
      chk({tag, "_rsp_tready"},    32'(bus.rsp_tready), 0);
      chk({tag, "_sample_data"},   32'(bus.sample_data), 0);
      chk({tag, "_sample_ch"},     32'(bus.sample_ch), 0);
      chk({tag, "_sample_valid"},  32'(bus.sample_valid), 0);
      chk({tag, "_sample_clip"},   32'(bus.sample_clip), 0);
      chk({tag, "_busy"},          32'(bus.busy), 0);
      chk({tag, "_timeout_pulse"}, 32'(bus.timeout_pulse), 0);
      chk({tag, "_timeout_count"}, 32'(bus.timeout_count), 0);
   endtask

   initial begin
      int e0;
      bus.start = 1'b0;
      bus.ch = 2'd0;
      bus.cmd_tready = 1'b0;
      bus.rsp_tdata = 8'h00;
      bus.rsp_tvalid = 1'b0;
      bus.sample_ready = 1'b0;

      tick;
      tick;
      check_all_zero("reset");
      rst = 1'b0;
      tick;
      chk("rsp_tready_up", 32'(bus.rsp_tready), 1);
      chk("idle_busy", 32'(bus.busy), 0);

      // stray byte in IDLE
      bus.rsp_tvalid = 1'b1;
      bus.rsp_tdata = 8'hFF;
      tick;
      bus.rsp_tvalid = 1'b0;
      chk("stray_busy", 32'(bus.busy), 0);
      chk("stray_valid", 32'(bus.sample_valid), 0);

      run_query(2'd2, 8'h34, 8'h01, 0, 1'b0);
      run_query(2'd0, 8'h78, 8'h02, 0, 1'b1);
      run_query(2'd0, 8'hC3, 8'h02, 10, 1'b0);
      run_query(2'd3, 8'h00, 8'h04, 0, 1'b0);

      // timeout in WAIT_HI after one byte
      begin_query(2'd1);
      bus.rsp_tvalid = 1'b1;
      bus.rsp_tdata = 8'h55;
      tick;
      e0 = cyc;
      bus.rsp_tvalid = 1'b0;
      for (int i = 0; i < 40 && !bus.timeout_pulse; i++) tick;
      chk("to_hi_pulse", 32'(bus.timeout_pulse), 1);
      chk("to_hi_delay", 32'(cyc - e0), TO);
      chk("to_hi_busy", 32'(bus.busy), 0);
      chk("to_hi_novalid", 32'(bus.sample_valid), 0);
      chk("to_hi_count", 32'(bus.timeout_count), 1);
      tick;
      chk("to_pulse_width", 32'(bus.timeout_pulse), 0);
      run_query(2'd1, 8'h10, 8'h00, 0, 1'b0);

      // timeout in WAIT_LO, exact point
      begin_query(2'd3);
      e0 = cyc;
      for (int i = 0; i < 40 && !bus.timeout_pulse; i++) tick;
      chk("to_lo_pulse", 32'(bus.timeout_pulse), 1);
      chk("to_lo_delay", 32'(cyc - e0), TO);
      chk("to_lo_count", 32'(bus.timeout_count), 2);

      // byte arriving on the terminal cycle wins
      tick;
      begin_query(2'd1);
      repeat (TO - 1) tick;
      bus.rsp_tvalid = 1'b1;
      bus.rsp_tdata = 8'h22;
      tick;
      bus.rsp_tvalid = 1'b0;
      chk("race_nopulse", 32'(bus.timeout_pulse), 0);
      chk("race_busy", 32'(bus.busy), 1);
      chk("race_count", 32'(bus.timeout_count), 2);
      bus.rsp_tvalid = 1'b1;
      bus.rsp_tdata = 8'h03;
      sb.push_back(model(2'd1, 8'h22, 8'h03));
      tick;
      bus.rsp_tvalid = 1'b0;
      chk("race_valid", 32'(bus.sample_valid), 1);
      check_out("race");
      bus.sample_ready = 1'b1;
      tick;
      bus.sample_ready = 1'b0;
      chk("race_release", 32'(bus.sample_valid), 0);

      // reset during WAIT_HI
      begin_query(2'd2);
      bus.rsp_tvalid = 1'b1;
      bus.rsp_tdata = 8'h11;
      tick;
      bus.rsp_tvalid = 1'b0;
      chk("pre_rst_busy", 32'(bus.busy), 1);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      tick;
      rst = 1'b0;
      bus.rsp_tvalid = 1'b1;
      bus.rsp_tdata = 8'h11;
      tick;
      bus.rsp_tdata = 8'h22;
      tick;
      bus.rsp_tvalid = 1'b0;
      tick;
      chk("postrst_busy", 32'(bus.busy), 0);
      chk("postrst_valid", 32'(bus.sample_valid), 0);
      chk("postrst_cmd", 32'(bus.cmd_tvalid), 0);
      chk("postrst_count", 32'(bus.timeout_count), 0);

      run_query(2'd2, 8'hAB, 8'h00, 0, 1'b0);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
